// File: rtl/usb_tx_pkg.sv
// Shared constants and types for the USB full-speed transmit bit sequencer.
// Provides the state encoding, SYNC pattern, bit-stuff limit, EOP length,
// {dp,dm} line-level constants and the NRZI next-level helper.
package usb_tx_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned ONES_W   = 3;
  localparam int unsigned LINE_W   = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } tx_state_t;

  localparam logic [BYTE_W-1:0] SYNC_BYTE    = 8'h80;
  localparam logic [ONES_W-1:0] STUFF_LIMIT  = 3'd6;
  localparam int unsigned       EOP_SE0_BITS = 2;

  // Line levels as {dp, dm}
  localparam logic [LINE_W-1:0] LINE_J   = 2'b10;
  localparam logic [LINE_W-1:0] LINE_K   = 2'b01;
  localparam logic [LINE_W-1:0] LINE_SE0 = 2'b00;

  // NRZI: a 0 toggles J/K, a 1 holds the current level
  function automatic logic [LINE_W-1:0] nrzi_next(input logic [LINE_W-1:0] line,
                                                  input logic              bit_val);
    return bit_val ? line : ~line;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Modulo counter: counts 0 .. rollover_val-1 on count_enable, wraps to 0.
// Ports: clk, n_rst (async active-low), clear (sync, has priority),
//        count_enable, rollover_val, count_out (registered).
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_n;

  // Next count: clear wins, otherwise increment with wrap
  always_comb begin
    count_n = count_out;
    if (clear) begin
      count_n = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val - NUM_CNT_BITS'(1)) count_n = '0;
      else                                              count_n = count_out + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_out <= '0;
    else        count_out <= count_n;
  end

endmodule

// File: rtl/usb_tx_bit_sequencer.sv
// USB full-speed transmit bit sequencer: SYNC, NRZI bit-stuffed data
// (LSB first) pulled through a one-byte holding register, then EOP.
// Ports: clk, n_rst; tx_start; tx_byte/byte_valid/last_byte/byte_ready
// handshake; bit_strobe from divider, div_en/div_clear to divider;
// dp_out/dm_out line levels; tx_busy, tx_done and tx_err status.
module usb_tx_bit_sequencer
  import usb_tx_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              tx_start,
  input  logic [BYTE_W-1:0] tx_byte,
  input  logic              byte_valid,
  input  logic              last_byte,
  input  logic              bit_strobe,
  output logic              byte_ready,
  output logic              div_en,
  output logic              div_clear,
  output logic              dp_out,
  output logic              dm_out,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_err
);

  localparam logic [CNT_W-1:0] SYNC_BITS = CNT_W'(8);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(7);
  localparam logic [CNT_W-1:0] SE0_LAST  = CNT_W'(EOP_SE0_BITS - 1);

  tx_state_t          state_q,      state_n;
  logic [LINE_W-1:0]  line_q,       line_n;
  logic [ONES_W-1:0]  ones_q,       ones_n;
  logic [CNT_W-1:0]   aux_q,        aux_n;
  logic [BYTE_W-1:0]  hold_byte_q,  hold_byte_n;
  logic               hold_last_q,  hold_last_n;
  logic               hold_full_q,  hold_full_n;
  logic [BYTE_W-1:0]  shift_q,      shift_n;
  logic               cur_last_q,   cur_last_n;
  logic               last_taken_q, last_taken_n;
  logic               byte_ready_n, div_en_n, div_clear_n;
  logic               tx_busy_n, tx_done_n, tx_err_n;

  logic               strobe, byte_take, stuff_due;
  logic               tx_bit, tx_bit_en, do_boundary, load, start;
  logic [BYTE_W-1:0]  src_byte;
  logic [CNT_W-1:0]   bit_cnt;

  assign strobe    = bit_strobe & div_en;
  assign byte_take = byte_valid & byte_ready;
  assign stuff_due = (ones_q == STUFF_LIMIT);
  assign dp_out    = line_q[1];
  assign dm_out    = line_q[0];

  // Index of the data bit currently on the line; stuffed bits do not advance it
  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_bit_idx (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (load | start),
    .count_enable (strobe & (state_q == DATA) & ~stuff_due),
    .rollover_val (CNT_W'(8)),
    .count_out    (bit_cnt)
  );

  // Next-state and next-output logic
  always_comb begin
    state_n      = state_q;
    line_n       = line_q;
    ones_n       = ones_q;
    aux_n        = aux_q;
    hold_byte_n  = hold_byte_q;
    hold_last_n  = hold_last_q;
    hold_full_n  = hold_full_q;
    shift_n      = shift_q;
    cur_last_n   = cur_last_q;
    last_taken_n = last_taken_q;
    div_clear_n  = 1'b0;
    tx_done_n    = 1'b0;
    tx_err_n     = 1'b0;
    tx_bit       = 1'b0;
    tx_bit_en    = 1'b0;
    do_boundary  = 1'b0;
    load         = 1'b0;
    start        = 1'b0;
    src_byte     = hold_byte_q;

    if (byte_take) begin
      hold_byte_n = tx_byte;
      hold_last_n = last_byte;
      hold_full_n = 1'b1;
      if (last_byte) last_taken_n = 1'b1;
    end

    case (state_q)
      IDLE: begin
        line_n = LINE_J;
        if (tx_start) begin
          state_n      = SYNC;
          div_clear_n  = 1'b1;
          start        = 1'b1;
          ones_n       = '0;
          aux_n        = '0;
          cur_last_n   = 1'b0;
          last_taken_n = 1'b0;
          hold_full_n  = 1'b0;
        end
      end
      SYNC: if (strobe) begin
        if (aux_q == SYNC_BITS) begin
          do_boundary = 1'b1;
        end else begin
          tx_bit    = SYNC_BYTE[aux_q[2:0]];
          tx_bit_en = 1'b1;
          aux_n     = aux_q + CNT_W'(1);
        end
      end
      DATA: if (strobe) begin
        // A stuffed bit is simply a transmitted 0 that leaves the index alone
        if (stuff_due) begin
          tx_bit_en = 1'b1;
        end else if (bit_cnt == LAST_BIT) begin
          do_boundary = 1'b1;
        end else begin
          tx_bit    = shift_q[bit_cnt[2:0] + 3'd1];
          tx_bit_en = 1'b1;
        end
      end
      EOP_SE0: if (strobe) begin
        if (aux_q == SE0_LAST) begin
          state_n = EOP_J;
          line_n  = LINE_J;
        end else begin
          aux_n = aux_q + CNT_W'(1);
        end
      end
      EOP_J: if (strobe) begin
        state_n   = IDLE;
        tx_done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Byte boundary: a capture on this same cycle counts (bypass the hold)
    if (do_boundary) begin
      if (hold_full_q || byte_take) begin
        src_byte    = hold_full_q ? hold_byte_q : tx_byte;
        load        = 1'b1;
        hold_full_n = 1'b0;
        shift_n     = src_byte;
        cur_last_n  = hold_full_q ? hold_last_q : last_byte;
        tx_bit      = src_byte[0];
        tx_bit_en   = 1'b1;
        state_n     = DATA;
      end else begin
        state_n  = EOP_SE0;
        line_n   = LINE_SE0;
        aux_n    = '0;
        tx_err_n = ~cur_last_q;
      end
    end

    if (tx_bit_en) begin
      line_n = nrzi_next(line_q, tx_bit);
      ones_n = tx_bit ? ones_q + ONES_W'(1) : '0;
    end

    tx_busy_n    = (state_n != IDLE);
    div_en_n     = (state_q != IDLE) && (state_n != IDLE);
    byte_ready_n = ((state_n == SYNC) || (state_n == DATA)) && !hold_full_n && !last_taken_n;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      line_q       <= LINE_J;
      ones_q       <= '0;
      aux_q        <= '0;
      hold_byte_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      cur_last_q   <= 1'b0;
      last_taken_q <= 1'b0;
      byte_ready   <= 1'b0;
      div_en       <= 1'b0;
      div_clear    <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      state_q      <= state_n;
      line_q       <= line_n;
      ones_q       <= ones_n;
      aux_q        <= aux_n;
      hold_byte_q  <= hold_byte_n;
      hold_last_q  <= hold_last_n;
      hold_full_q  <= hold_full_n;
      shift_q      <= shift_n;
      cur_last_q   <= cur_last_n;
      last_taken_q <= last_taken_n;
      byte_ready   <= byte_ready_n;
      div_en       <= div_en_n;
      div_clear    <= div_clear_n;
      tx_busy      <= tx_busy_n;
      tx_done      <= tx_done_n;
      tx_err       <= tx_err_n;
    end
  end

endmodule
